tdm_mux_rr: RTL and testbench
=============================

// Module: tdm_mux_rr
// PURPOSE
//  Parametrised N-channel word multiplexer for the comm-system transmit path. It
//  buffers one word per input channel and merges all channels onto one output
//  stream with valid/ready handshakes. Two modes: work-conserving round-robin
//  (empty channels skipped) or fixed TDM slots (filler word in empty slots).
//  Sits between the channel sources and the serialiser/line encoder.
// PARAMETERS
//  NUM_CH     4      number of input channels (>=1)
//  W          8      word width in bits
//  MODE       0      0 = round-robin skip-empty, 1 = fixed TDM slots
//  IDLE_WORD  8'h00  filler word sent in an empty TDM slot (MODE=1)
//  CH_W       localparam = max(1,$clog2(NUM_CH))
// PORTS
//  clk              in   1         single clock, rising edge
//  rst              in   1         asynchronous active-high reset
//  in_data          in   NUM_CH*W  channel i word at [i*W +: W]
//  in_valid         in   NUM_CH    per-channel word valid
//  in_ready         out  NUM_CH    per-channel buffer can accept
//  out_data         out  W         merged output word
//  out_ch           out  CH_W      source channel index of out_data
//  out_valid        out  1         out_data/out_ch/flags valid
//  out_ready        in   1         downstream accepts
//  out_frame_start  out  1         MODE=1: slot 0 of a frame; MODE=0: always 0
//  out_idle         out  1         MODE=1: out_data is IDLE_WORD filler; MODE=0: 0
// BEHAVIOUR
//  - Reset (async, rst=1): buf_full[] = 0, ptr = 0, out_valid = 0, out_data = 0,
//    out_ch = 0, out_frame_start = 0, out_idle = 0. Buffered words are dropped
//    mid-operation. in_ready = all 1 once rst deasserts.
//  - adv = ~out_valid | out_ready: the output register may load this cycle.
//  - Per-channel 1-word buffer: load on in_valid[i] & in_ready[i].
//    in_ready[i] = ~buf_full[i] | grant[i]. A load and a grant on the same
//    channel in the same cycle leave buf_full[i] = 1 with the new word.
//    Otherwise a grant clears buf_full[i].
//    in_ready is combinational from out_ready (no registered path).
//  - MODE=0 (round-robin): when adv, grant the first i with buf_full[i], searching
//    ptr, ptr+1, ... mod NUM_CH.
//    If found: out_data <= buf[i], out_ch <= i, out_valid <= 1, ptr <= (i+1) mod NUM_CH.
//    If none: out_valid <= 0, ptr unchanged.
//  - MODE=1 (TDM): every adv cycle after reset emits slot ptr.
//    out_valid <= 1, out_ch <= ptr, out_frame_start <= (ptr==0), ptr <= ptr+1
//    wrapping NUM_CH-1 -> 0.
//    If buf_full[ptr]: out_data <= buf[ptr], out_idle <= 0, grant ptr.
//    Else: out_data <= IDLE_WORD, out_idle <= 1.
//  - Stall (out_valid & ~out_ready): all outputs and ptr hold, no grant issued.
//    Buffers stay full, so in_ready drops for full channels.
//  - Latency: word accepted at edge t -> at earliest on out_* after edge t+1.
//    This holds if the word is granted first.
//  - Throughput: one word per cycle at the output. Each channel can sustain one
//    word per cycle while it is granted every cycle.
//  - NUM_CH=1: ptr is constant 0. In MODE=1, out_frame_start = 1 on every slot.
// TESTING
//  1 MODE0 NUM_CH=4 W=8, out_ready=1: load ch1=8'hA1 and ch3=8'hC3 in the same cycle.
//    -> (ch1,A1) then (ch3,C3) on consecutive cycles, then out_valid=0.
//  2 MODE0, all 4 channels valid continuously, out_ready=1.
//    -> out_ch sequence 0,1,2,3,0,1..., no gaps, in_ready[i] pulses only when
//    channel i is granted.
//  3 MODE0, out_ready=0 for 5 cycles with all buffers full.
//    -> out_* held stable, in_ready=4'b0000. On release, order resumes from the
//    held ch+1.
//  4 MODE1 IDLE_WORD=8'hEE, only ch2 sends 8'h52.
//    -> slots 0,1,3 show EE with out_idle=1. Slot 2 shows 52 with out_idle=0.
//    out_frame_start=1 only with out_ch=0.
//  5 MODE1, out_ready toggling 1/0 every cycle.
//    -> no slot skipped or repeated, out_ch increments by 1 per accepted word.
//  6 rst pulse while ch0 and ch2 are buffered and out_valid=1.
//    -> outputs go to 0 immediately, both words dropped, first grant after
//    reset starts search at ch0.

Source files
------------

// File: rtl/tdm_mux_rr.sv
// N-channel word multiplexer. Each channel has a one-word buffer, and all channels are
// merged onto one valid/ready output stream, either round-robin skipping empty channels or in fixed TDM slots.
module tdm_mux_rr #(
  parameter int             NUM_CH    = 4,
  parameter int             W         = 8,
  parameter int             MODE      = 0,
  parameter logic [W-1:0]   IDLE_WORD = '0,
  localparam int            CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*W-1:0]   in_data,
  input  logic [NUM_CH-1:0]     in_valid,
  output logic [NUM_CH-1:0]     in_ready,
  output logic [W-1:0]          out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_frame_start,
  output logic                  out_idle
);

  logic [W-1:0]      word_buf [NUM_CH];
  logic [NUM_CH-1:0] buf_full;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] load;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_inc;
  logic [CH_W-1:0]   rr_sel;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W:0]     idx;
  logic              rr_found;
  logic              adv;

  assign adv = ~out_valid | out_ready;

  // First full buffer at or after ptr, wrapping modulo NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    idx      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, ptr} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH)) begin
        idx = idx - (CH_W+1)'(NUM_CH);
      end
      if (!rr_found && buf_full[idx[CH_W-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = idx[CH_W-1:0];
      end
    end
  end

  assign ptr_inc = (ptr    == CH_W'(NUM_CH-1)) ? '0 : ptr    + CH_W'(1);
  assign rr_next = (rr_sel == CH_W'(NUM_CH-1)) ? '0 : rr_sel + CH_W'(1);

  always_comb begin
    grant = '0;
    if (adv) begin
      if (MODE == 0) begin
        if (rr_found) begin
          grant[rr_sel] = 1'b1;
        end
      end else if (buf_full[ptr]) begin
        grant[ptr] = 1'b1;
      end
    end
  end

  // A granted buffer frees its slot in the same cycle, so a source can stream back-to-back.
  assign in_ready = ~buf_full | grant;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          buf_full[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) begin
        word_buf[i] <= in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_ch          <= '0;
      out_frame_start <= 1'b0;
      out_idle        <= 1'b0;
    end else if (adv) begin
      if (MODE == 0) begin
        out_frame_start <= 1'b0;
        out_idle        <= 1'b0;
        if (rr_found) begin
          out_valid <= 1'b1;
          out_data  <= word_buf[rr_sel];
          out_ch    <= rr_sel;
          ptr       <= rr_next;
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        // A TDM slot is always emitted; empty slots carry the filler word.
        out_valid       <= 1'b1;
        out_ch          <= ptr;
        out_frame_start <= (ptr == '0);
        ptr             <= ptr_inc;
        if (buf_full[ptr]) begin
          out_data <= word_buf[ptr];
          out_idle <= 1'b0;
        end else begin
          out_data <= IDLE_WORD;
          out_idle <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_rr.sv
// Bench for tdm_mux_rr. One instance runs in round-robin mode and one in TDM mode.
// Expected words are queued by the stimulus, and monitors check them on each output transfer.
module tb_tdm_mux_rr;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
    logic       fs;
    logic       idle;
  } exp_t;

  logic        clk;
  logic        rst_rr, rst_tdm;
  logic [31:0] in_data_rr, in_data_tdm;
  logic [3:0]  in_valid_rr, in_valid_tdm;
  logic [3:0]  in_ready_rr, in_ready_tdm;
  logic [7:0]  out_data_rr, out_data_tdm;
  logic [1:0]  out_ch_rr, out_ch_tdm;
  logic        out_valid_rr, out_valid_tdm;
  logic        out_ready_rr, out_ready_tdm;
  logic        out_frame_start_rr, out_frame_start_tdm;
  logic        out_idle_rr, out_idle_tdm;

  exp_t q_rr[$];
  exp_t q_tdm[$];
  int   vectors = 0;
  int   miscompares = 0;

  tdm_mux_rr #(.NUM_CH(4), .W(8), .MODE(0), .IDLE_WORD(8'h00)) u_rr (
    .clk(clk), .rst(rst_rr), .in_data(in_data_rr), .in_valid(in_valid_rr),
    .in_ready(in_ready_rr), .out_data(out_data_rr), .out_ch(out_ch_rr),
    .out_valid(out_valid_rr), .out_ready(out_ready_rr),
    .out_frame_start(out_frame_start_rr), .out_idle(out_idle_rr)
  );

  tdm_mux_rr #(.NUM_CH(4), .W(8), .MODE(1), .IDLE_WORD(8'hEE)) u_tdm (
    .clk(clk), .rst(rst_tdm), .in_data(in_data_tdm), .in_valid(in_valid_tdm),
    .in_ready(in_ready_tdm), .out_data(out_data_tdm), .out_ch(out_ch_tdm),
    .out_valid(out_valid_tdm), .out_ready(out_ready_tdm),
    .out_frame_start(out_frame_start_tdm), .out_idle(out_idle_tdm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] valid_rr, input logic [31:0] data_rr,
                                input logic [3:0] valid_tdm, input logic [31:0] data_tdm);
    in_valid_rr  = valid_rr;
    in_data_rr   = data_rr;
    in_valid_tdm = valid_tdm;
    in_data_tdm  = data_tdm;
  endtask

  function automatic void exp_rr(input logic [1:0] ch, input logic [7:0] d);
    q_rr.push_back({d, ch, 1'b0, 1'b0});
  endfunction

  function automatic void exp_tdm(input logic [1:0] ch, input logic [7:0] d, input logic fs, input logic idle);
    q_tdm.push_back({d, ch, fs, idle});
  endfunction

  // Output monitors: each accepted word must match the head of its queue.
  always @(negedge clk) begin
    if (!rst_rr && out_valid_rr && out_ready_rr) begin
      if (q_rr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL rr_unexpected: got ch %0d data %h required no output", out_ch_rr, out_data_rr);
      end else begin
        check_output("rr_word", {out_data_rr, out_ch_rr, out_frame_start_rr, out_idle_rr}, q_rr.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_tdm && out_valid_tdm && out_ready_tdm) begin
      if (q_tdm.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL tdm_unexpected: got ch %0d data %h required no output", out_ch_tdm, out_data_tdm);
      end else begin
        check_output("tdm_slot", {out_data_tdm, out_ch_tdm, out_frame_start_tdm, out_idle_tdm}, q_tdm.pop_front());
      end
    end
  end

  initial begin
    rst_rr = 1'b0;
    rst_tdm = 1'b0;
    out_ready_rr = 1'b1;
    out_ready_tdm = 1'b0;
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    #1;
    rst_rr = 1'b1;
    rst_tdm = 1'b1;
    repeat (2) step();

    check_output("rst_rr_valid", out_valid_rr, 0);
    check_output("rst_rr_data", out_data_rr, 0);
    check_output("rst_rr_ch", out_ch_rr, 0);
    check_output("rst_tdm_valid", out_valid_tdm, 0);
    check_output("rst_tdm_flags", {out_frame_start_tdm, out_idle_tdm}, 0);
    rst_rr = 1'b0;
    rst_tdm = 1'b0;
    @(negedge clk);
    check_output("rst_rr_in_ready", in_ready_rr, 4'hF);
    check_output("rst_tdm_in_ready", in_ready_tdm, 4'hF);
    check_output("rst_rr_idle_valid", out_valid_rr, 0);

    // Two channels loaded together leave in order, then the stream goes idle.
    step();
    apply_stimulus(4'b1010, {8'hC3, 8'h00, 8'hA1, 8'h00}, 4'h0, 32'h0);
    exp_rr(2'd1, 8'hA1);
    exp_rr(2'd3, 8'hC3);
    step();
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    repeat (3) step();
    @(negedge clk);
    check_output("t1_drained", out_valid_rr, 0);

    // All channels stream continuously, and each in_ready pulses only on its own grant.
    step();
    apply_stimulus(4'hF, {8'h23, 8'h22, 8'h21, 8'h20}, 4'h0, 32'h0);
    for (int n = 0; n < 11; n++) exp_rr(2'(n % 4), 8'(8'h20 + n % 4));
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      check_output("t2_in_ready", in_ready_rr, (m == 0) ? 4'hF : 4'(1 << ((m - 1) % 4)));
      if (m >= 2) check_output("t2_no_gap", out_valid_rr, 1);
      step();
    end
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    repeat (6) step();
    @(negedge clk);
    check_output("t2_drained", out_valid_rr, 0);

    // Stall with every buffer full, then release.
    step();
    out_ready_rr = 1'b0;
    apply_stimulus(4'hF, {8'h33, 8'h32, 8'h31, 8'h30}, 4'h0, 32'h0);
    step();
    @(negedge clk);
    check_output("t3_grant_ready", in_ready_rr, 4'b1000);
    step();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_output("t3_hold", {out_valid_rr, out_ch_rr, out_data_rr}, {1'b1, 2'd3, 8'h33});
      check_output("t3_in_ready", in_ready_rr, 4'b0000);
      step();
    end
    exp_rr(2'd3, 8'h33);
    exp_rr(2'd0, 8'h30);
    exp_rr(2'd1, 8'h31);
    exp_rr(2'd2, 8'h32);
    exp_rr(2'd3, 8'h33);
    out_ready_rr = 1'b1;
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    repeat (8) step();
    @(negedge clk);
    check_output("t3_drained", out_valid_rr, 0);

    // Reset mid-operation drops buffered words and restarts the search at ch0.
    step();
    out_ready_rr = 1'b0;
    apply_stimulus(4'b0101, {8'h00, 8'h42, 8'h00, 8'h40}, 4'h0, 32'h0);
    step();
    step();
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check_output("t6_pre_valid", out_valid_rr, 1);
    rst_rr = 1'b1;
    #1;
    check_output("t6_async_out", {out_valid_rr, out_ch_rr, out_data_rr}, 0);
    step();
    rst_rr = 1'b0;
    out_ready_rr = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_output("t6_dropped", out_valid_rr, 0);
      step();
    end
    apply_stimulus(4'b1001, {8'h53, 8'h00, 8'h00, 8'h50}, 4'h0, 32'h0);
    exp_rr(2'd0, 8'h50);
    exp_rr(2'd3, 8'h53);
    step();
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    repeat (4) step();

    // TDM: only ch2 carries data, and every other slot carries filler.
    @(negedge clk);
    check_output("t4_tdm_in_ready", in_ready_tdm, 4'hF);
    step();
    apply_stimulus(4'h0, 32'h0, 4'b0100, {8'h00, 8'h52, 8'h00, 8'h00});
    step();
    apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
    out_ready_tdm = 1'b1;
    exp_tdm(2'd0, 8'hEE, 1'b1, 1'b1);
    exp_tdm(2'd1, 8'hEE, 1'b0, 1'b1);
    exp_tdm(2'd2, 8'h52, 1'b0, 1'b0);
    exp_tdm(2'd3, 8'hEE, 1'b0, 1'b1);
    exp_tdm(2'd0, 8'hEE, 1'b1, 1'b1);
    exp_tdm(2'd1, 8'hEE, 1'b0, 1'b1);
    exp_tdm(2'd2, 8'hEE, 1'b0, 1'b1);
    exp_tdm(2'd3, 8'hEE, 1'b0, 1'b1);
    repeat (8) step();
    out_ready_tdm = 1'b0;
    @(negedge clk);
    check_output("t4_hold_slot0", {out_valid_tdm, out_ch_tdm, out_frame_start_tdm}, {1'b1, 2'd0, 1'b1});

    // TDM with a toggling out_ready: no slot is skipped or repeated.
    step();
    exp_tdm(2'd0, 8'hEE, 1'b1, 1'b1);
    exp_tdm(2'd1, 8'hEE, 1'b0, 1'b1);
    exp_tdm(2'd2, 8'hEE, 1'b0, 1'b1);
    exp_tdm(2'd3, 8'h73, 1'b0, 1'b0);
    exp_tdm(2'd0, 8'hEE, 1'b1, 1'b1);
    exp_tdm(2'd1, 8'hEE, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      out_ready_tdm = (k % 2 == 0);
      if (k == 0) apply_stimulus(4'h0, 32'h0, 4'b1000, {8'h73, 8'h00, 8'h00, 8'h00});
      else        apply_stimulus(4'h0, 32'h0, 4'h0, 32'h0);
      step();
    end
    out_ready_tdm = 1'b0;

    for (int t = 0; t < 50 && (q_rr.size() != 0 || q_tdm.size() != 0); t++) step();
    check_output("rr_queue_empty", q_rr.size(), 0);
    check_output("tdm_queue_empty", q_tdm.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
